mem_viewer_display: RTL and testbench

MEM_VIEWER_DISPLAY -- requirements
Module: mem_viewer_display

---
 rtl/mem_viewer_display.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mem_viewer_display.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_viewer_display.sv
// Memory word viewer: debounced next/prev buttons walk an index, the addressed word is fetched
// and shown in hex on a multiplexed 7-segment display alongside the index (hex or decimal).
module mem_viewer_display #(
    parameter int MEM_DEPTH    = 17,
    parameter int DATA_W       = 16,
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 2**17,
    parameter int DEBOUNCE_CYC = 2**16,
    parameter int REPEAT_DLY   = 2**25,
    parameter int REPEAT_PER   = 2**22,
    parameter int WRAP         = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic                         idx_dec,
    output logic                         rd_en,
    output logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
    input  logic [DATA_W-1:0]            rd_data,
    input  logic                         rd_valid,
    output logic [6:0]                   seg,
    output logic                         dp,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [$clog2(MEM_DEPTH)-1:0] index
);
    localparam int AW      = $clog2(MEM_DEPTH);
    localparam int VAL_DIG = DATA_W / 4;
    localparam int IDX_DIG = NUM_DIGITS - VAL_DIG;
    localparam int DW      = $clog2(NUM_DIGITS);
    localparam logic [AW-1:0] IDX_ONE  = 1;
    localparam logic [AW-1:0] IDX_LAST = AW'(MEM_DEPTH - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Bit 0 = next, bit 1 = prev
    logic [1:0] btn_raw;
    logic [1:0] step_pulse;
    assign btn_raw = {btn_prev, btn_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic        sync1_reg, sync2_reg, level_reg, level_d_reg;
            logic        rep_phase_reg, step_reg;
            logic [31:0] deb_cnt_reg, rep_cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != level_reg) begin
                        if (deb_cnt_reg == 32'(DEBOUNCE_CYC - 1)) begin
                            level_reg   <= sync2_reg;
                            deb_cnt_reg <= '0;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + 32'd1;
                        end
                    end else begin
                        deb_cnt_reg <= '0;
                    end
                end
            end

            // Press steps once; after REPEAT_DLY of holding, repeat steps every REPEAT_PER
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    level_d_reg   <= 1'b0;
                    rep_phase_reg <= 1'b0;
                    rep_cnt_reg   <= '0;
                    step_reg      <= 1'b0;
                end else begin
                    level_d_reg <= level_reg;
                    step_reg    <= 1'b0;
                    if (!level_reg) begin
                        rep_phase_reg <= 1'b0;
                        rep_cnt_reg   <= '0;
                    end else if (!level_d_reg) begin
                        step_reg      <= 1'b1;
                        rep_phase_reg <= 1'b0;
                        rep_cnt_reg   <= '0;
                    end else if (!rep_phase_reg) begin
                        if (rep_cnt_reg == 32'(REPEAT_DLY - 1)) begin
                            rep_phase_reg <= 1'b1;
                            rep_cnt_reg   <= '0;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 32'd1;
                        end
                    end else if (rep_cnt_reg == 32'(REPEAT_PER - 1)) begin
                        step_reg    <= 1'b1;
                        rep_cnt_reg <= '0;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg + 32'd1;
                    end
                end
            end

            assign step_pulse[gi] = step_reg;
        end
    endgenerate

    logic [AW-1:0] index_reg, index_next;
    logic          idx_chg;

    always_comb begin
        index_next = index_reg;
        if (step_pulse[0] && !step_pulse[1]) begin
            if (index_reg == IDX_LAST)
                index_next = (WRAP != 0) ? '0 : index_reg;
            else
                index_next = index_reg + IDX_ONE;
        end else if (step_pulse[1] && !step_pulse[0]) begin
            if (index_reg == '0)
                index_next = (WRAP != 0) ? IDX_LAST : index_reg;
            else
                index_next = index_reg - IDX_ONE;
        end
    end
    assign idx_chg = (index_next != index_reg);

    // Scan timing
    logic [31:0]   div_reg;
    logic [DW-1:0] digit_reg;
    logic          tick, frame_end;
    assign tick      = (div_reg == 32'(REFRESH_DIV - 1));
    assign frame_end = tick && (digit_reg == DW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg   <= '0;
            digit_reg <= '0;
        end else if (tick) begin
            div_reg   <= '0;
            digit_reg <= (digit_reg == DW'(NUM_DIGITS - 1)) ? '0 : digit_reg + DW'(1);
        end else begin
            div_reg <= div_reg + 32'd1;
        end
    end

    state_t              state_reg, state_next;
    logic                init_reg, init_next;
    logic                pending_reg, pending_next;
    logic [DATA_W-1:0]   value_reg, value_next;

    always_comb begin
        state_next   = state_reg;
        init_next    = init_reg;
        pending_next = pending_reg;
        value_next   = value_reg;
        case (state_reg)
            S_IDLE: begin
                if (init_reg || idx_chg || frame_end) begin
                    state_next = S_REQ;
                    init_next  = 1'b0;
                end
            end
            S_REQ: begin
                state_next   = S_WAIT;
                pending_next = idx_chg;
            end
            S_WAIT: begin
                if (rd_valid) begin
                    value_next = rd_data;
                    if (pending_reg || idx_chg) begin
                        state_next   = S_REQ;
                        pending_next = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (idx_chg) begin
                    pending_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            init_reg    <= 1'b1;
            pending_reg <= 1'b0;
            value_reg   <= '0;
            index_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            init_reg    <= init_next;
            pending_reg <= pending_next;
            value_reg   <= value_next;
            index_reg   <= index_next;
        end
    end

    assign rd_en   = (state_reg == S_REQ);
    assign rd_addr = index_reg;
    assign index   = index_reg;

    // Index field as 8 nibbles: BCD via double-dabble or plain hex
    logic [31:0] idx_bcd, idx_rep;
    logic        idx_ovf;

    always_comb begin
        idx_bcd = '0;
        for (int i = AW - 1; i >= 0; i--) begin
            for (int d = 0; d < 8; d++) begin
                if (idx_bcd[4*d +: 4] >= 4'd5)
                    idx_bcd[4*d +: 4] = idx_bcd[4*d +: 4] + 4'd3;
            end
            idx_bcd = {idx_bcd[30:0], index_reg[i]};
        end
    end

    assign idx_rep = idx_dec ? idx_bcd : 32'(index_reg);
    assign idx_ovf = ((idx_rep >> (4 * IDX_DIG)) != 32'd0);

    logic [IDX_DIG-1:0] idx_blank;
    logic [6:0]         glyph [NUM_DIGITS];

    generate
        for (gi = 0; gi < IDX_DIG; gi++) begin : g_blank
            if (gi == 0) begin : g_keep
                assign idx_blank[gi] = 1'b0;
            end else begin : g_lead
                assign idx_blank[gi] = ((idx_rep >> (4 * gi)) == 32'd0);
            end
        end
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph
            if (gi < VAL_DIG) begin : g_val
                assign glyph[gi] = hex_glyph(value_reg[4*gi +: 4]);
            end else begin : g_idx
                assign glyph[gi] = idx_ovf ? SEG_DASH :
                                   idx_blank[gi-VAL_DIG] ? SEG_BLANK :
                                   hex_glyph(idx_rep[4*(gi-VAL_DIG) +: 4]);
            end
        end
    endgenerate

    // an, seg and dp all load on the same edge so a digit never shows its neighbour's pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << digit_reg);
            seg <= glyph[digit_reg];
            dp  <= (digit_reg == DW'(VAL_DIG)) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_viewer_display.sv
// Directed bench for mem_viewer_display: reset, reads, debounce, auto-repeat, saturate/wrap,
// pending re-read, index radix/blanking and reset mid-operation.
module tb_mem_viewer_display;
    logic        clk = 1'b0;
    logic        rst, btn_next, btn_prev, idx_dec;
    logic        rd_en, rd_valid, dp;
    logic [4:0]  rd_addr, index;
    logic [15:0] rd_data;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        w_rd_en, w_dp;
    logic [4:0]  w_rd_addr, w_index;
    logic [6:0]  w_seg;
    logic [7:0]  w_an;

    int total = 0;
    int bad = 0;
    int mem_lat = 3;
    int mcnt = 0;
    logic mbusy = 1'b0;
    logic [4:0] maddr = '0;
    int rd_cnt = 0;
    int chg_cnt = 0;
    int viol = 0;
    logic [4:0] last_addr = '0;
    logic [4:0] prev_idx = '0;
    logic outst = 1'b0;
    logic [6:0] seg_cap [8];
    logic       dp_cap [8];

    always #5 clk = ~clk;

    mem_viewer_display #(.MEM_DEPTH(17), .DATA_W(16), .NUM_DIGITS(8), .REFRESH_DIV(4),
        .DEBOUNCE_CYC(4), .REPEAT_DLY(40), .REPEAT_PER(8), .WRAP(0)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .idx_dec(idx_dec),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .seg(seg), .dp(dp), .an(an), .index(index));

    mem_viewer_display #(.MEM_DEPTH(17), .DATA_W(16), .NUM_DIGITS(8), .REFRESH_DIV(4),
        .DEBOUNCE_CYC(4), .REPEAT_DLY(40), .REPEAT_PER(8), .WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .idx_dec(idx_dec),
        .rd_en(w_rd_en), .rd_addr(w_rd_addr), .rd_data(16'h0000), .rd_valid(1'b0),
        .seg(w_seg), .dp(w_dp), .an(w_an), .index(w_index));

    function automatic logic [15:0] mdata(input logic [4:0] a);
        return (a == 5'd0) ? 16'hBEEF : (16'h1000 + {11'd0, a});
    endfunction

    // Memory model with adjustable latency; also tracks reads and outstanding requests
    always @(posedge clk) begin
        if (rst) begin
            mbusy    <= 1'b0;
            rd_valid <= 1'b0;
            outst    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (mbusy) begin
                if (mcnt == 1) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mdata(maddr);
                    mbusy    <= 1'b0;
                end
                mcnt <= mcnt - 1;
            end
            if (rd_en) begin
                mbusy     <= 1'b1;
                mcnt      <= mem_lat - 1;
                maddr     <= rd_addr;
                rd_cnt    <= rd_cnt + 1;
                last_addr <= rd_addr;
                if (outst) viol <= viol + 1;
                outst <= 1'b1;
            end else if (rd_valid) begin
                outst <= 1'b0;
            end
        end
        if (index !== prev_idx) chg_cnt <= chg_cnt + 1;
        prev_idx <= index;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_rd_en(input int maxc);
        int n = 0;
        while (rd_en !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_rd_en", 32'(rd_en), 32'd1);
    endtask

    task automatic wait_rd_valid(input int maxc);
        int n = 0;
        while (rd_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_rd_valid", 32'(rd_valid), 32'd1);
    endtask

    task automatic tap(input bit nxt, input int hold, input int gap);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic capture(input int ncyc);
        logic [7:0] onehot;
        for (int d = 0; d < 8; d++) begin
            seg_cap[d] = 'x;
            dp_cap[d]  = 1'bx;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                onehot = 8'(1) << d;
                if (an === ~onehot) begin
                    seg_cap[d] = seg;
                    dp_cap[d]  = dp;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; idx_dec = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_index", 32'(index), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_wrap_outs", {w_rd_en, w_dp, w_rd_addr, w_index, w_seg, w_an},
              {1'b0, 1'b1, 5'd0, 5'd0, 7'h7F, 8'hFF});

        // First read right after reset release, then BEEF on the display
        rst = 1'b0;
        check("rel_rd_en_low", 32'(rd_en), 32'd0);
        @(negedge clk);
        check("first_rd_en", 32'(rd_en), 32'd1);
        check("first_rd_addr", 32'(rd_addr), 32'd0);
        repeat (10) @(negedge clk);
        check("an_onehot", 32'($countones(~an)), 32'd1);
        capture(36);
        check("d0_F", 32'(seg_cap[0]), 32'h0E);
        check("d1_E", 32'(seg_cap[1]), 32'h06);
        check("d2_E", 32'(seg_cap[2]), 32'h06);
        check("d3_b", 32'(seg_cap[3]), 32'h03);
        check("d4_0", 32'(seg_cap[4]), 32'h40);
        check("d5_blank", 32'(seg_cap[5]), 32'h7F);
        check("d6_blank", 32'(seg_cap[6]), 32'h7F);
        check("d7_blank", 32'(seg_cap[7]), 32'h7F);
        check("dp4_on", 32'(dp_cap[4]), 32'd0);
        check("dp0_off", 32'(dp_cap[0]), 32'd1);

        // Bouncing press: short pulses rejected, one step from the stable part
        chg_cnt = 0;
        repeat (3) begin
            btn_next = 1'b1; repeat (3) @(negedge clk);
            btn_next = 1'b0; repeat (3) @(negedge clk);
        end
        tap(1'b1, 10, 20);
        repeat (20) @(negedge clk);
        check("bounce_index", 32'(index), 32'd1);
        check("bounce_steps", 32'(chg_cnt), 32'd1);
        check("bounce_rd_addr", 32'(last_addr), 32'd1);

        // Auto-repeat: hold 80 cycles from index 0
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        chg_cnt = 0;
        btn_next = 1'b1;
        repeat (45) @(negedge clk);
        check("hold_mid_index", 32'(index), 32'd1);
        repeat (35) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        check("hold80_index", 32'(index), 32'd5);
        check("hold80_steps", 32'(chg_cnt), 32'd5);
        check("hold80_wrap_index", 32'(w_index), 32'd5);

        // 12 more steps: saturate at 16 vs wrap to 0
        chg_cnt = 0;
        btn_next = 1'b1;
        repeat (132) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        check("sat_index", 32'(index), 32'd16);
        check("sat_steps", 32'(chg_cnt), 32'd11);
        check("wrap_index", 32'(w_index), 32'd0);

        // Two index changes during a long read: one follow-up read of the latest index
        mem_lat = 100;
        wait_rd_en(40);
        begin
            int base;
            base = rd_cnt;
            tap(1'b0, 10, 12);
            tap(1'b0, 10, 12);
            check("pend_index", 32'(index), 32'd14);
            wait_rd_valid(120);
            mem_lat = 3;
            check("pend_reads_in_wait", 32'(rd_cnt - base), 32'd1);
        end
        @(negedge clk);
        check("pend_rd_en", 32'(rd_en), 32'd1);
        check("pend_rd_addr", 32'(rd_addr), 32'd14);

        // Index 12 in decimal then hex
        tap(1'b0, 10, 12);
        tap(1'b0, 10, 12);
        check("idx12", 32'(index), 32'd12);
        idx_dec = 1'b1;
        repeat (40) @(negedge clk);
        capture(36);
        check("dec_d0_C", 32'(seg_cap[0]), 32'h46);
        check("dec_d3_1", 32'(seg_cap[3]), 32'h79);
        check("dec_d4_2", 32'(seg_cap[4]), 32'h24);
        check("dec_d5_1", 32'(seg_cap[5]), 32'h79);
        check("dec_d6_blank", 32'(seg_cap[6]), 32'h7F);
        check("dec_d7_blank", 32'(seg_cap[7]), 32'h7F);
        check("dec_dp4", 32'(dp_cap[4]), 32'd0);
        check("dec_dp5", 32'(dp_cap[5]), 32'd1);
        idx_dec = 1'b0;
        repeat (40) @(negedge clk);
        capture(36);
        check("hex_d4_C", 32'(seg_cap[4]), 32'h46);
        check("hex_d5_blank", 32'(seg_cap[5]), 32'h7F);
        check("hex_dp4", 32'(dp_cap[4]), 32'd0);

        // Reset while a read is outstanding
        mem_lat = 100;
        wait_rd_en(40);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_rd_en", 32'(rd_en), 32'd0);
        check("rstw_an", 32'(an), 32'hFF);
        check("rstw_seg", 32'(seg), 32'h7F);
        check("rstw_dp", 32'(dp), 32'd1);
        check("rstw_index", 32'(index), 32'd0);
        repeat (3) @(negedge clk);
        mem_lat = 3;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_rd_en_after", 32'(rd_en), 32'd1);
        check("rstw_rd_addr_after", 32'(rd_addr), 32'd0);
        repeat (20) @(negedge clk);

        // Reset during an auto-repeat hold: no late step afterwards
        btn_next = 1'b1;
        repeat (60) @(negedge clk);
        check("rsth_index_before", 32'(index), 32'd2);
        rst = 1'b1;
        #1;
        check("rsth_index", 32'(index), 32'd0);
        check("rsth_an", 32'(an), 32'hFF);
        btn_next = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        chg_cnt = 0;
        repeat (80) @(negedge clk);
        check("rsth_index_after", 32'(index), 32'd0);
        check("rsth_steps_after", 32'(chg_cnt), 32'd0);

        check("outstanding_viol", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
